instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Front end of the core: owns the program counter and drives instruction ROM addressing.
//  Presents the current instruction to the decode/control stage.
//  Consumes that stage's halt/branch/jump/relative/destBranchJump outputs plus the compare flag to pick the next PC.
//  Single-cycle issue; one instruction retired per cycle while running.
// PARAMETERS
//  PC_WIDTH     8   program counter / ROM address width; must be >= DATA_WIDTH
//  COUNT_WIDTH  16  width of retired-instruction counter
//  (INSN_WIDTH, DATA_WIDTH, INSN_HLT come from package definitions)
// PORTS
//  clk             in   1           rising-edge clock
//  reset_n         in   1           asynchronous, active-low reset
//  start           in   1           begin execution at address 0 (pulse)
//  halt            in   1           from control unit: current insn is HLT
//  branch          in   1           from control unit: conditional branch
//  jump            in   1           from control unit: unconditional jump
//  relative        in   1           1 = PC-relative target, 0 = absolute
//  destBranchJump  in   DATA_WIDTH  target / signed offset
//  compareFlag     in   1           registered compare result (branch taken when 1)
//  romAddr         out  PC_WIDTH    synchronous ROM read address (combinational = nextPc)
//  romData         in   INSN_WIDTH  ROM data, valid the cycle after romAddr is sampled
//  instruction     out  INSN_WIDTH  instruction to control unit
//  pc              out  PC_WIDTH    address of instruction
//  insnValid       out  1           1 only in RUN
//  done            out  1           1 only in HALTED
//  insnCount       out  COUNT_WIDTH retired instructions, saturating
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, pc=0, insnCount=0, insnValid=0, done=0; romAddr=0.
//  - FSM states and transitions:
//    - IDLE --start--> RUN.
//    - RUN --halt--> HALTED.
//    - HALTED --start--> RUN.
//    - start is ignored in RUN.
//  - Instruction output: instruction = romData in RUN; forced to INSN_HLT in IDLE/HALTED.
//    Decode therefore causes no side effects outside RUN.
//  - Control inputs are ignored outside RUN.
//  - nextPc selection, priority high to low:
//    - not RUN & start: 0.
//    - not RUN: pc.
//    - halt: pc (hold).
//    - jump: target.
//    - branch & compareFlag: target.
//    - otherwise: pc+1.
//  - Target computation:
//    - relative=1: pc + signext(destBranchJump to PC_WIDTH), i.e. offset from the branch's own address.
//    - relative=0: zero-extended destBranchJump.
//    - All PC arithmetic wraps modulo 2^PC_WIDTH.
//  - ROM addressing: romAddr = nextPc combinationally.
//    - pc <= nextPc each edge; ROM returns mem[nextPc] after the same edge, so romData always matches pc.
//    - Redirects have zero bubbles.
//  - Latency:
//    - start sampled at edge E -> pc=0, insnValid=1 and instruction=mem[0] after E.
//    - Taken branch at pc=p sampled at edge -> pc=target after that edge.
//  - insnCount:
//    - +1 at every edge while in RUN, including the HLT cycle.
//    - Holds at all-ones.
//    - Cleared to 0 on restart from HALTED.
//  - done asserts the cycle after the edge that sampled halt.
//  - Simultaneous events:
//    - halt with jump/branch: halt wins.
//    - branch with compareFlag=0: falls through to pc+1.
//    - jump and branch together: jump.
//  - Reset mid-operation: immediate return to IDLE regardless of state; no partial update survives.
//  - pc+1 at all-ones wraps to 0; no flag.
// TESTING
//  - Reset, start at T -> pc 0,1,2,3 on successive cycles; insnValid=1; instruction tracks ROM[pc]; done=0.
//  - Absolute jump: jump=1, relative=0, dest=8'h40 at pc=5 -> next pc=8'h40; no bubble cycle.
//  - Relative branch: at pc=8'h10, branch=1, relative=1, dest=8'hFC:
//    - compareFlag=1 -> pc=8'h0C.
//    - compareFlag=0 -> pc=8'h11.
//  - HLT at pc=3 with jump also asserted:
//    - pc holds at 3; done=1 next cycle; insnCount=4; instruction=INSN_HLT.
//    - start then -> pc=0, insnCount=0.
//  - Wrap and saturation:
//    - pc=8'hFF sequential -> pc=8'h00.
//    - relative offset 8'h7F from 8'hF0 -> 8'h6F.
//    - insnCount preloaded near max stops at 16'hFFFF.
//  - reset_n low mid-RUN (between clock edges) -> outputs go to reset values immediately; start required to resume at 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives synchronous ROM addressing and
// retires one instruction per cycle while running; next-PC is presented to the ROM combinationally.
package ifu_pkg;
  localparam int unsigned INSN_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 8;
  localparam logic [INSN_WIDTH-1:0] INSN_HLT = 16'hF000;
endpackage

module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   branch,
  input  logic                   jump,
  input  logic                   relative,
  input  logic [DATA_WIDTH-1:0]  destBranchJump,
  input  logic                   compareFlag,
  output logic [PC_WIDTH-1:0]    romAddr,
  input  logic [INSN_WIDTH-1:0]  romData,
  output logic [INSN_WIDTH-1:0]  instruction,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   insnValid,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] insnCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, next_pc, target, offset_sext, dest_zext;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   running;

  assign running     = (state_q == RUN);
  assign offset_sext = PC_WIDTH'($signed(destBranchJump));
  assign dest_zext   = PC_WIDTH'(destBranchJump);
  assign target      = relative ? (pc_q + offset_sext) : dest_zext;

  always_comb begin
    next_pc = pc_q;
    if (!running) begin
      if (start) next_pc = '0;
    end else if (halt) begin
      next_pc = pc_q;
    end else if (jump) begin
      next_pc = target;
    end else if (branch && compareFlag) begin
      next_pc = target;
    end else begin
      next_pc = pc_q + PC_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: if (start) state_d = RUN;
      RUN:          if (halt)  state_d = HALTED;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= next_pc;
      // Counts the HLT cycle too; a restart clears it before counting resumes.
      if (running) begin
        if (!(&count_q)) count_q <= count_q + COUNT_WIDTH'(1);
      end else if (start) begin
        count_q <= '0;
      end
    end
  end

  assign romAddr     = next_pc;
  assign pc          = pc_q;
  assign insnValid   = running;
  assign done        = (state_q == HALTED);
  assign instruction = running ? romData : INSN_HLT;
  assign insnCount   = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a ROM model, hand-derived expected PCs/counts,
// plus a narrow-counter instance to exercise saturation.
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, start, halt, branch, jump, relative, compare_flag;
  logic [7:0]  dest_bj;
  logic [7:0]  rom_addr, pc, s_rom_addr, s_pc;
  logic [15:0] rom_data, instruction, s_instruction, insn_count;
  logic        insn_valid, done, s_insn_valid, s_done;
  logic [3:0]  s_insn_count;
  logic [15:0] mem [256];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic st, hl, br, jp, rl, cf;
    logic [7:0]  dst;
    logic [7:0]  epc;
    logic        ev, ed;
    logic [15:0] ecnt;
  } step_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic        valid, done;
    logic [15:0] cnt;
    logic [15:0] insn;
    logic [3:0]  scnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  instruction_fetch_unit #(.PC_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt), .branch(branch),
    .jump(jump), .relative(relative), .destBranchJump(dest_bj), .compareFlag(compare_flag),
    .romAddr(rom_addr), .romData(rom_data), .instruction(instruction), .pc(pc),
    .insnValid(insn_valid), .done(done), .insnCount(insn_count)
  );

  instruction_fetch_unit #(.PC_WIDTH(8), .COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt), .branch(branch),
    .jump(jump), .relative(relative), .destBranchJump(dest_bj), .compareFlag(compare_flag),
    .romAddr(s_rom_addr), .romData(rom_data), .instruction(s_instruction), .pc(s_pc),
    .insnValid(s_insn_valid), .done(s_done), .insnCount(s_insn_count)
  );

  function automatic step_t S(input logic st, hl, br, jp, rl, cf, input logic [7:0] dst,
                              input logic [7:0] epc, input logic ev, ed, input logic [15:0] ecnt);
    step_t s;
    s.st = st; s.hl = hl; s.br = br; s.jp = jp; s.rl = rl; s.cf = cf; s.dst = dst;
    s.epc = epc; s.ev = ev; s.ed = ed; s.ecnt = ecnt;
    return s;
  endfunction

  task automatic apply(input step_t s);
    exp_t e;
    start = s.st; halt = s.hl; branch = s.br; jump = s.jp;
    relative = s.rl; compare_flag = s.cf; dest_bj = s.dst;
    e.pc    = s.epc;
    e.valid = s.ev;
    e.done  = s.ed;
    e.cnt   = s.ecnt;
    e.insn  = s.ev ? mem[s.epc] : INSN_HLT;
    e.scnt  = (s.ecnt > 16'd15) ? 4'hF : s.ecnt[3:0];
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    reset_n = 1'b0;
    apply(S(0,0,0,0,0,0,8'h00, 8'h00,0,0,0));
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pc !== 8'h00 || insn_valid !== 1'b0 || done !== 1'b0 || insn_count !== 16'h0 ||
        rom_addr !== 8'h00 || instruction !== INSN_HLT) begin
      n_fail++;
      $display("FAIL reset: pc=%h valid=%b done=%b cnt=%h romAddr=%h insn=%h, required 00 0 0 0000 00 %h",
               pc, insn_valid, done, insn_count, rom_addr, instruction, INSN_HLT);
    end
    reset_n = 1'b1;
    // IDLE with control inputs active must stay put
    apply(S(0,0,1,1,0,1,8'h55, 8'h00,0,0,0));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || insn_valid !== e.valid || done !== e.done || insn_count !== e.cnt ||
        instruction !== e.insn) begin
      n_fail++;
      $display("FAIL idle_hold: pc=%h valid=%b done=%b cnt=%h insn=%h, required %h %b %b %h %h",
               pc, insn_valid, done, insn_count, instruction, e.pc, e.valid, e.done, e.cnt, e.insn);
    end
  endtask

  task automatic run_steps_seq(input string name, input step_t steps[$]);
    exp_t e;
    foreach (steps[i]) begin
      apply(steps[i]);
      #1;
      n_checks++;
      if (rom_addr !== steps[i].epc) begin
        n_fail++;
        $display("FAIL %s romAddr step %0d: got %h, required %h", name, i, rom_addr, steps[i].epc);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || insn_valid !== e.valid || done !== e.done || insn_count !== e.cnt ||
          instruction !== e.insn) begin
        n_fail++;
        $display("FAIL %s step %0d: pc=%h valid=%b done=%b cnt=%h insn=%h, required %h %b %b %h %h",
                 name, i, pc, insn_valid, done, insn_count, instruction,
                 e.pc, e.valid, e.done, e.cnt, e.insn);
      end
      n_checks++;
      if (s_insn_count !== e.scnt) begin
        n_fail++;
        $display("FAIL %s sat_count step %0d: got %h, required %h", name, i, s_insn_count, e.scnt);
      end
    end
  endtask

  task automatic test_sequential;
    step_t s[$];
    s.push_back(S(1,0,0,0,0,0,8'h00, 8'h00,1,0,0));
    s.push_back(S(0,0,0,0,0,0,8'h00, 8'h01,1,0,1));
    s.push_back(S(1,0,0,0,0,0,8'h00, 8'h02,1,0,2));
    s.push_back(S(0,0,0,0,0,0,8'h00, 8'h03,1,0,3));
    run_steps_seq("sequential", s);
  endtask

  task automatic test_halt;
    step_t s[$];
    s.push_back(S(0,1,0,1,0,0,8'h40, 8'h03,0,1,4));
    s.push_back(S(0,0,1,1,1,1,8'h20, 8'h03,0,1,4));
    s.push_back(S(1,0,0,0,0,0,8'h00, 8'h00,1,0,0));
    run_steps_seq("halt", s);
  endtask

  task automatic test_abs_jump;
    step_t s[$];
    for (int i = 1; i <= 5; i++) s.push_back(S(0,0,0,0,0,0,8'h00, 8'(i),1,0,16'(i)));
    s.push_back(S(0,0,0,1,0,0,8'h40, 8'h40,1,0,6));
    s.push_back(S(0,0,0,0,0,0,8'h00, 8'h41,1,0,7));
    run_steps_seq("abs_jump", s);
  endtask

  task automatic test_rel_branch;
    step_t s[$];
    s.push_back(S(0,0,0,1,0,0,8'h10, 8'h10,1,0,8));
    s.push_back(S(0,0,1,0,1,1,8'hFC, 8'h0C,1,0,9));
    s.push_back(S(0,0,0,1,0,0,8'h10, 8'h10,1,0,10));
    s.push_back(S(0,0,1,0,1,0,8'hFC, 8'h11,1,0,11));
    s.push_back(S(0,0,1,1,0,0,8'h03, 8'h03,1,0,12));
    s.push_back(S(0,0,1,0,0,1,8'h30, 8'h30,1,0,13));
    run_steps_seq("branch", s);
  endtask

  task automatic test_wrap;
    step_t s[$];
    s.push_back(S(0,0,0,1,0,0,8'hFF, 8'hFF,1,0,14));
    s.push_back(S(0,0,0,0,0,0,8'h00, 8'h00,1,0,15));
    s.push_back(S(0,0,0,1,0,0,8'hF0, 8'hF0,1,0,16));
    s.push_back(S(0,0,0,1,1,0,8'h7F, 8'h6F,1,0,17));
    s.push_back(S(0,0,1,0,1,1,8'h80, 8'hEF,1,0,18));
    run_steps_seq("wrap", s);
  endtask

  task automatic test_saturation;
    step_t s[$];
    for (int i = 1; i <= 10; i++) s.push_back(S(0,0,0,0,0,0,8'h00, 8'(8'hEF + i),1,0,16'(18 + i)));
    run_steps_seq("saturation", s);
  endtask

  task automatic test_reset_mid;
    step_t s[$];
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pc !== 8'h00 || insn_valid !== 1'b0 || done !== 1'b0 || insn_count !== 16'h0 ||
        rom_addr !== 8'h00 || instruction !== INSN_HLT || s_insn_count !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid: pc=%h valid=%b done=%b cnt=%h romAddr=%h insn=%h scnt=%h, required 00 0 0 0000 00 %h 0",
               pc, insn_valid, done, insn_count, rom_addr, instruction, s_insn_count, INSN_HLT);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    s.push_back(S(0,0,0,1,0,0,8'h55, 8'h00,0,0,0));
    s.push_back(S(1,0,0,0,0,0,8'h00, 8'h00,1,0,0));
    s.push_back(S(0,0,0,0,0,0,8'h00, 8'h01,1,0,1));
    run_steps_seq("reset_mid", s);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    start = 0; halt = 0; branch = 0; jump = 0; relative = 0; compare_flag = 0; dest_bj = '0;
    reset_n = 1'b0;
    test_reset;
    test_sequential;
    test_halt;
    test_abs_jump;
    test_rel_branch;
    test_wrap;
    test_saturation;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "timeout");
  end

endmodule
